// File: rtl/text_overlay_pkg.sv
// Shared constants and state encoding for the text overlay controller.
package text_overlay_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int DEPTH = COLS * ROWS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [7:0] CLEAR_CODE = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/text_overlay_ctrl_text_ram.sv
// Character code store: one synchronous write port, one registered read
// port. A same-address read and write in one cycle returns the old code.
module text_ram
  import text_overlay_pkg::*;
#(
  parameter int N_WORDS = DEPTH,
  parameter int AW      = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [N_WORDS];

  // write port; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port, sampled before any same-cycle write lands
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text overlay controller: two round-robin write requesters, a full-screen
// clear sequence, and a two-stage display read path that never stalls.
//
//   state | meaning
//   IDLE  | accepting writes from requesters
//   CLEAR | writing CLEAR_CODE to every cell, one per cycle
module text_overlay_ctrl
  import text_overlay_pkg::*;
#(
  parameter int         COLS       = text_overlay_pkg::COLS,
  parameter int         ROWS       = text_overlay_pkg::ROWS,
  parameter logic [7:0] CLEAR_CODE = text_overlay_pkg::CLEAR_CODE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blank,
  input  logic         vsync,
  input  logic [7:0]   char_x,
  input  logic [7:0]   char_y,
  input  logic [255:0] ascii_char,
  input  logic         wr0_valid,
  output logic         wr0_ready,
  input  logic [6:0]   wr0_col,
  input  logic [5:0]   wr0_row,
  input  logic [7:0]   wr0_code,
  input  logic         wr1_valid,
  output logic         wr1_ready,
  input  logic [6:0]   wr1_col,
  input  logic [5:0]   wr1_row,
  input  logic [7:0]   wr1_code,
  input  logic         clear_req,
  output logic         busy,
  output logic         pix_on,
  output logic         blank_out,
  output logic         vsync_out
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr;
  logic          clr_last;
  logic          prio;
  logic          gnt0, gnt1, xfer0, xfer1;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [7:0]    ram_wdata, code_q;
  logic          rd_in_range, oob_q, blank_d1, vsync_d1;

  assign clr_last = (clr_addr == AW'(CELLS - 1));
  assign busy     = (state == CLEAR);
  assign xfer0    = wr0_valid && wr0_ready;
  assign xfer1    = wr1_valid && wr1_ready;

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register, clear address counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clr_addr <= '0;
      prio     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_last ? '0 : clr_addr + AW'(1);
      if (xfer0)      prio <= 1'b1;
      else if (xfer1) prio <= 1'b0;
    end
  end

  // grant selection; a same-cycle clear request blocks both requesters
  always_comb begin
    gnt0      = wr0_valid && (!wr1_valid || !prio);
    gnt1      = wr1_valid && (!wr0_valid || prio);
    wr0_ready = 1'b0;
    wr1_ready = 1'b0;
    if (!reset && state == IDLE && !clear_req) begin
      wr0_ready = gnt0;
      wr1_ready = gnt1;
    end
  end

  // write port mux; reset suppresses the in-flight clear write
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr;
    ram_wdata = CLEAR_CODE;
    if (state == CLEAR) begin
      ram_we = !reset;
    end else if (xfer0) begin
      ram_we    = (32'(wr0_col) < COLS) && (32'(wr0_row) < ROWS);
      ram_waddr = AW'(wr0_row) * AW'(COLS) + AW'(wr0_col);
      ram_wdata = wr0_code;
    end else if (xfer1) begin
      ram_we    = (32'(wr1_col) < COLS) && (32'(wr1_row) < ROWS);
      ram_waddr = AW'(wr1_row) * AW'(COLS) + AW'(wr1_col);
      ram_wdata = wr1_code;
    end
  end

  assign rd_in_range = (32'(char_x) < COLS) && (32'(char_y) < ROWS);
  assign ram_raddr   = rd_in_range ? AW'(char_y) * AW'(COLS) + AW'(char_x) : '0;

  text_ram #(
    .N_WORDS (CELLS),
    .AW      (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (code_q)
  );

  // display pipeline: stage 1 aligns with ascii_char, stage 2 drives pixels
  always_ff @(posedge clk) begin
    if (reset) begin
      oob_q     <= 1'b0;
      blank_d1  <= 1'b0;
      vsync_d1  <= 1'b0;
      pix_on    <= 1'b0;
      blank_out <= 1'b1;
      vsync_out <= 1'b0;
    end else begin
      oob_q     <= !rd_in_range;
      blank_d1  <= blank;
      vsync_d1  <= vsync;
      pix_on    <= ascii_char[code_q] && !oob_q && !blank_d1;
      blank_out <= blank_d1;
      vsync_out <= vsync_d1;
    end
  end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Directed bench for text_overlay_ctrl; cell contents are observed through
// the display path by lighting a single font bit for the expected code.
module tb_text_overlay_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         blank, vsync;
  logic [7:0]   char_x, char_y;
  logic [255:0] ascii_char;
  logic         wr0_valid, wr0_ready;
  logic [6:0]   wr0_col;
  logic [5:0]   wr0_row;
  logic [7:0]   wr0_code;
  logic         wr1_valid, wr1_ready;
  logic [6:0]   wr1_col;
  logic [5:0]   wr1_row;
  logic [7:0]   wr1_code;
  logic         clear_req, busy, pix_on, blank_out, vsync_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  text_overlay_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .blank      (blank),
    .vsync      (vsync),
    .char_x     (char_x),
    .char_y     (char_y),
    .ascii_char (ascii_char),
    .wr0_valid  (wr0_valid),
    .wr0_ready  (wr0_ready),
    .wr0_col    (wr0_col),
    .wr0_row    (wr0_row),
    .wr0_code   (wr0_code),
    .wr1_valid  (wr1_valid),
    .wr1_ready  (wr1_ready),
    .wr1_col    (wr1_col),
    .wr1_row    (wr1_row),
    .wr1_code   (wr1_code),
    .clear_req  (clear_req),
    .busy       (busy),
    .pix_on     (pix_on),
    .blank_out  (blank_out),
    .vsync_out  (vsync_out)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic write_cell(input int port, input logic [6:0] col, input logic [5:0] row,
                            input logic [7:0] code, input string name);
    bit done = 1'b0;
    @(posedge clk); #1;
    if (port == 0) begin
      wr0_valid = 1'b1; wr0_col = col; wr0_row = row; wr0_code = code;
    end else begin
      wr1_valid = 1'b1; wr1_col = col; wr1_row = row; wr1_code = code;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port == 0 && wr0_ready) || (port == 1 && wr1_ready)) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: handshake got no ready within 20 cycles, required ready", name);
    end
  endtask

  // one cycle on an out-of-range row, then the target: pix_on must be 0 then 1
  task automatic check_cell(input int x, input int y, input logic [7:0] code, input string name);
    logic early, late;
    @(posedge clk); #1;
    blank = 1'b0;
    ascii_char = '0;
    ascii_char[code] = 1'b1;
    char_x = 8'(x);
    char_y = 8'd60;
    @(posedge clk); #1;
    char_y = 8'(y);
    @(posedge clk);
    @(negedge clk) early = pix_on;
    @(negedge clk) late = pix_on;
    vectors++;
    if ({early, late} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s: cell (%0d,%0d) pix_on t+1/t+2 got %b required 01 for code %0h",
               name, x, y, {early, late}, code);
    end
  endtask

  task automatic scan_cells(input int lo, input int hi, input logic [7:0] code, input string name);
    int bad = 0;
    int first_bad = -1;
    @(posedge clk); #1;
    blank = 1'b0;
    ascii_char = '0;
    ascii_char[code] = 1'b1;
    for (int i = lo; i <= hi + 2; i++) begin
      @(posedge clk); #1;
      if (i <= hi) begin
        char_x = 8'(i % 80);
        char_y = 8'(i / 80);
      end else begin
        char_y = 8'd60;
      end
      @(negedge clk);
      if (i - 2 >= lo && pix_on !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = i - 2;
      end
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s: %0d cells in %0d..%0d differ from code %0h (first %0d), required 0",
               name, bad, lo, hi, code, first_bad);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; blank = 1'b0; vsync = 1'b1; clear_req = 1'b1;
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    ascii_char = '1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, wr0_ready, wr1_ready, pix_on, blank_out, vsync_out} !== 6'b000010) begin
      miscompares++;
      $display("FAIL reset_outputs: {busy,rdy0,rdy1,pix,blank_out,vsync_out} got %b required 000010",
               {busy, wr0_ready, wr1_ready, pix_on, blank_out, vsync_out});
    end
    @(posedge clk); #1;
    clear_req = 1'b0; vsync = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_clear_ignored: busy got %b required 0", busy);
    end
  endtask

  task automatic test_write();
    write_cell(0, 7'd2, 6'd1, 8'h41, "write_handshake");
    vectors++;
    if (dut.u_ram.mem[82] !== 8'h41) begin
      miscompares++;
      $display("FAIL write_addr82: cell 82 got %0h required 41", dut.u_ram.mem[82]);
    end
    check_cell(2, 1, 8'h41, "write_pix");
  endtask

  task automatic test_arbitration();
    logic [1:0] got, exp;
    do_reset();
    @(posedge clk); #1;
    wr0_valid = 1'b1; wr0_col = 7'd10; wr0_row = 6'd5; wr0_code = 8'h50;
    wr1_valid = 1'b1; wr1_col = 7'd11; wr1_row = 6'd5; wr1_code = 8'h51;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      got = {wr1_ready, wr0_ready};
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL arb_grant%0d: {rdy1,rdy0} got %b required %b", k, got, exp);
      end
    end
    @(posedge clk); #1;
    wr0_valid = 1'b0;
    wr1_col = 7'd80;
    @(negedge clk);
    vectors++;
    if ({wr1_ready, wr0_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL arb_lone1: {rdy1,rdy0} got %b required 10", {wr1_ready, wr0_ready});
    end
    @(posedge clk); #1 wr1_valid = 1'b0;
    check_cell(10, 5, 8'h50, "arb_data0");
    check_cell(11, 5, 8'h51, "arb_data1");
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    int ready_busy = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    clear_req = 1'b1;
    wr0_valid = 1'b1; wr0_col = 7'd80; wr0_row = 6'd0;
    wr1_valid = 1'b1; wr1_col = 7'd80; wr1_row = 6'd0;
    @(negedge clk);
    vectors++;
    if ({wr0_ready, wr1_ready, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL clear_priority: {rdy0,rdy1,busy} got %b required 000",
               {wr0_ready, wr1_ready, busy});
    end
    for (int n = 0; n < 6000; n++) begin
      @(posedge clk); #1;
      clear_req = (n == 2000);
      @(negedge clk);
      if (busy && (wr0_ready || wr1_ready)) ready_busy++;
      if (busy) busy_cycles++;
      else begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    clear_req = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_done: busy still high after 6000 cycles, required low");
    end
    vectors++;
    if (busy_cycles !== 4800) begin
      miscompares++;
      $display("FAIL clear_length: busy cycles got %0d required 4800", busy_cycles);
    end
    vectors++;
    if (ready_busy !== 0) begin
      miscompares++;
      $display("FAIL clear_ready_low: ready-while-busy cycles got %0d required 0", ready_busy);
    end
    scan_cells(0, 4799, 8'h20, "clear_fill");
  endtask

  task automatic test_boundary();
    int px [3] = '{3, 80, 3};
    int py [3] = '{60, 0, 0};
    logic pe [3] = '{1'b0, 1'b0, 1'b1};
    write_cell(0, 7'd80, 6'd0, 8'h99, "oob_col_handshake");
    check_cell(0, 1, 8'h20, "oob_col_alias");
    check_cell(79, 0, 8'h20, "oob_col_prev");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ascii_char = '1;
      char_x = 8'(px[i]);
      char_y = 8'(py[i]);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (pix_on !== pe[i]) begin
        miscompares++;
        $display("FAIL oob_read(%0d,%0d): pix_on got %b required %b", px[i], py[i], pix_on, pe[i]);
      end
    end
  endtask

  task automatic test_blank_align();
    logic [2:0] s [3];
    logic [2:0] e [3] = '{3'b001, 3'b110, 3'b001};
    @(posedge clk); #1;
    ascii_char = '0;
    ascii_char[8'h20] = 1'b1;
    char_x = 8'd5; char_y = 8'd5; blank = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 blank = 1'b1; vsync = 1'b1;
    @(posedge clk); #1 blank = 1'b0; vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s[i] = {blank_out, vsync_out, pix_on};
      vectors++;
      if (s[i] !== e[i]) begin
        miscompares++;
        $display("FAIL blank_align_t%0d: {blank_out,vsync_out,pix} got %b required %b",
                 i + 1, s[i], e[i]);
      end
    end
    @(posedge clk); #1;
    char_x = 8'd7; char_y = 8'd7;
    wr0_valid = 1'b1; wr0_col = 7'd7; wr0_row = 6'd7; wr0_code = 8'h33;
    @(negedge clk);
    vectors++;
    if (wr0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rbw_handshake: wr0_ready got %b required 1", wr0_ready);
    end
    @(posedge clk); #1 wr0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (pix_on !== 1'b1) begin
      miscompares++;
      $display("FAIL rbw_old_code: pix_on for code 20 got %b required 1", pix_on);
    end
    check_cell(7, 7, 8'h33, "rbw_new_code");
  endtask

  task automatic test_reset_mid_clear();
    write_cell(1, 7'd0, 6'd0, 8'h11, "pre_w0");
    write_cell(1, 7'd19, 6'd1, 8'h12, "pre_w99");
    write_cell(0, 7'd20, 6'd1, 8'h13, "pre_w100");
    write_cell(0, 7'd70, 6'd1, 8'h14, "pre_w150");
    write_cell(1, 7'd79, 6'd59, 8'h15, "pre_w4799");
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midclear_busy: busy at clear cycle 100 got %b required 1", busy);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midclear_abort: busy after reset got %b required 0", busy);
    end
    scan_cells(0, 99, 8'h20, "midclear_done_cells");
    check_cell(20, 1, 8'h13, "midclear_keep100");
    check_cell(70, 1, 8'h14, "midclear_keep150");
    check_cell(79, 59, 8'h15, "midclear_keep4799");
  endtask

  initial begin
    reset = 1'b1; blank = 1'b1; vsync = 1'b0;
    char_x = '0; char_y = '0; ascii_char = '0;
    wr0_valid = 1'b0; wr0_col = '0; wr0_row = '0; wr0_code = '0;
    wr1_valid = 1'b0; wr1_col = '0; wr1_row = '0; wr1_code = '0;
    clear_req = 1'b0;
    test_reset();
    test_write();
    test_arbitration();
    test_clear();
    test_boundary();
    test_blank_align();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
